// File: rtl/fifo_arbiter.sv
// Round-robin arbiter guarding one synchronous FIFO shared by two writers and one reader.
// Define FIFO_ARB_RD_PRIO_EN to give the reader strict priority over the round-robin writers.
module fifo_arbiter #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr0_req,
    input  logic [DW-1:0] wr0_data,
    output logic          wr0_gnt,
    input  logic          wr1_req,
    input  logic [DW-1:0] wr1_data,
    output logic          wr1_gnt,
    input  logic          rd_req,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          fifo_wen,
    output logic          fifo_ren,
    output logic [DW-1:0] fifo_din,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_error,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          err
);

    typedef enum logic [1:0] {
        SLOT_WR0 = 2'd0,
        SLOT_WR1 = 2'd1,
        SLOT_RD  = 2'd2
    } slot_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    slot_t         ptr_q, ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    logic          err_q, err_d;

    logic elig_wr0, elig_wr1, elig_rd;
    logic gnt_wr0, gnt_wr1, gnt_rd;

    // Eligibility looks only at the registered count, so a write this cycle never enables a read this cycle.
    assign elig_wr0 = wr0_req && (count_q < DEPTH_C);
    assign elig_wr1 = wr1_req && (count_q < DEPTH_C);
    assign elig_rd  = rd_req  && (count_q != '0);

    always_comb begin
        gnt_wr0 = 1'b0;
        gnt_wr1 = 1'b0;
        gnt_rd  = 1'b0;
        ptr_d   = ptr_q;
        if (rst_n) begin
`ifdef FIFO_ARB_RD_PRIO_EN
            if (elig_rd) begin
                gnt_rd = 1'b1;
            end else if (ptr_q == SLOT_WR1) begin
                if (elig_wr1) begin
                    gnt_wr1 = 1'b1;
                    ptr_d   = SLOT_WR0;
                end else if (elig_wr0) begin
                    gnt_wr0 = 1'b1;
                    ptr_d   = SLOT_WR1;
                end
            end else begin
                if (elig_wr0) begin
                    gnt_wr0 = 1'b1;
                    ptr_d   = SLOT_WR1;
                end else if (elig_wr1) begin
                    gnt_wr1 = 1'b1;
                    ptr_d   = SLOT_WR0;
                end
            end
`else
            case (ptr_q)
                SLOT_WR0: begin
                    if (elig_wr0) begin
                        gnt_wr0 = 1'b1;
                        ptr_d   = SLOT_WR1;
                    end else if (elig_wr1) begin
                        gnt_wr1 = 1'b1;
                        ptr_d   = SLOT_RD;
                    end else if (elig_rd) begin
                        gnt_rd = 1'b1;
                        ptr_d  = SLOT_WR0;
                    end
                end
                SLOT_WR1: begin
                    if (elig_wr1) begin
                        gnt_wr1 = 1'b1;
                        ptr_d   = SLOT_RD;
                    end else if (elig_rd) begin
                        gnt_rd = 1'b1;
                        ptr_d  = SLOT_WR0;
                    end else if (elig_wr0) begin
                        gnt_wr0 = 1'b1;
                        ptr_d   = SLOT_WR1;
                    end
                end
                default: begin
                    if (elig_rd) begin
                        gnt_rd = 1'b1;
                        ptr_d  = SLOT_WR0;
                    end else if (elig_wr0) begin
                        gnt_wr0 = 1'b1;
                        ptr_d   = SLOT_WR1;
                    end else if (elig_wr1) begin
                        gnt_wr1 = 1'b1;
                        ptr_d   = SLOT_RD;
                    end
                end
            endcase
`endif
        end
    end

    always_comb begin
        count_d = count_q;
        if (gnt_wr0 || gnt_wr1) begin
            count_d = count_q + CW'(1);
        end else if (gnt_rd) begin
            count_d = count_q - CW'(1);
        end
        rd_valid_d = gnt_rd;
        err_d      = err_q | fifo_error;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= SLOT_WR0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign wr0_gnt  = gnt_wr0;
    assign wr1_gnt  = gnt_wr1;
    assign rd_gnt   = gnt_rd;
    assign fifo_wen = gnt_wr0 | gnt_wr1;
    assign fifo_ren = gnt_rd;
    assign fifo_din = gnt_wr0 ? wr0_data : (gnt_wr1 ? wr1_data : '0);
    assign rd_valid = rd_valid_q;
    assign rd_data  = fifo_dout;
    assign count    = count_q;
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign err      = err_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed self-checking bench for fifo_arbiter with a behavioural 8x8 FIFO behind it.
// Honours FIFO_ARB_RD_PRIO_EN for the grant patterns that depend on it.
module tb_fifo_arbiter;

    logic       clk;
    logic       rst_n;
    logic       wr0_req, wr1_req, rd_req;
    logic [7:0] wr0_data, wr1_data;
    logic       wr0_gnt, wr1_gnt, rd_gnt;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       fifo_wen, fifo_ren;
    logic [7:0] fifo_din;
    logic [7:0] fifo_dout;
    logic       fifo_error;
    logic [3:0] count;
    logic       full, empty, err;

    logic       err_inject;
    logic [2:0] gnt_vec;

    int checks;
    int failures;

    fifo_arbiter #(.DW(8), .DEPTH(8), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr0_req(wr0_req), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
        .wr1_req(wr1_req), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .fifo_wen(fifo_wen), .fifo_ren(fifo_ren), .fifo_din(fifo_din),
        .fifo_dout(fifo_dout), .fifo_error(fifo_error),
        .count(count), .full(full), .empty(empty), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign gnt_vec = {wr0_gnt, wr1_gnt, rd_gnt};

    // Behavioural FIFO: registered dout on read, flags any illegal operation on its error pin.
    logic [7:0] mem [8];
    logic [2:0] fw, fr;
    logic [3:0] fc;
    logic       illegal;

    assign illegal    = rst_n && ((fifo_wen && fifo_ren) || (fifo_wen && fc == 4'd8) || (fifo_ren && fc == 4'd0));
    assign fifo_error = err_inject | illegal;

    always @(posedge clk) begin
        if (!rst_n) begin
            fw        <= 3'd0;
            fr        <= 3'd0;
            fc        <= 4'd0;
            fifo_dout <= 8'd0;
        end else begin
            if (fifo_wen && fc != 4'd8) begin
                mem[fw] <= fifo_din;
                fw      <= fw + 3'd1;
            end
            if (fifo_ren && fc != 4'd0) begin
                fifo_dout <= mem[fr];
                fr        <= fr + 3'd1;
            end
            if ((fifo_wen && fc != 4'd8) && !(fifo_ren && fc != 4'd0)) fc <= fc + 4'd1;
            else if (!(fifo_wen && fc != 4'd8) && (fifo_ren && fc != 4'd0)) fc <= fc - 4'd1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic w0, input logic [7:0] d0,
                                 input logic w1, input logic [7:0] d1, input logic r);
        @(negedge clk);
        wr0_req  = w0;
        wr0_data = d0;
        wr1_req  = w1;
        wr1_data = d1;
        rd_req   = r;
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n      = 1'b0;
        wr0_req    = 1'b0;
        wr1_req    = 1'b0;
        rd_req     = 1'b0;
        err_inject = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fillWords(input int n, input logic [7:0] base);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = base + 8'(i);
            applyStimulus(1'b1, d, 1'b0, 8'd0, 1'b0);
            checkOutput("fill_count", 32'(count), 32'(i));
            checkOutput("fill_gnt", 32'(gnt_vec), 32'(3'b100));
            checkOutput("fill_din", 32'(fifo_din), 32'(d));
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_data;
        logic [7:0] da, db;
        logic       exp_valid;
        logic [2:0] exp_g;
        logic [3:0] exp_count;

        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        wr0_req    = 1'b0;
        wr1_req    = 1'b0;
        rd_req     = 1'b0;
        wr0_data   = 8'd0;
        wr1_data   = 8'd0;
        err_inject = 1'b0;

        // Reset with every request raised: grants must stay low.
        @(negedge clk);
        wr0_req = 1'b1;
        wr1_req = 1'b1;
        rd_req  = 1'b1;
        #1;
        checkOutput("rst_gnt", 32'(gnt_vec), 32'd0);
        checkOutput("rst_wen", 32'(fifo_wen), 32'd0);
        checkOutput("rst_ren", 32'(fifo_ren), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_rdvalid", 32'(rd_valid), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        rst_n   = 1'b1;
        wr0_req = 1'b0;
        wr1_req = 1'b0;
        rd_req  = 1'b0;

        // Fill to the brim, then one rejected write.
        fillWords(8, 8'h11);
        applyStimulus(1'b1, 8'h19, 1'b0, 8'd0, 1'b0);
        checkOutput("full_count", 32'(count), 32'd8);
        checkOutput("full_flag", 32'(full), 32'd1);
        checkOutput("full_gnt", 32'(gnt_vec), 32'd0);
        checkOutput("full_wen", 32'(fifo_wen), 32'd0);

        // Drain eight words in order, ninth request refused.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
            if (i > 0) begin
                checkOutput("drain_rdvalid", 32'(rd_valid), 32'd1);
                checkOutput("drain_rddata", 32'(rd_data), 32'(8'h11 + 8'(i - 1)));
            end
            checkOutput("drain_count", 32'(count), 32'(8 - i));
            checkOutput("drain_gnt", 32'(rd_gnt), (i < 8) ? 32'd1 : 32'd0);
            checkOutput("drain_ren", 32'(fifo_ren), (i < 8) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        checkOutput("drain_end_rdvalid", 32'(rd_valid), 32'd0);
        checkOutput("drain_end_empty", 32'(empty), 32'd1);

        // Fairness with all three requesters active from empty.
        resetDut();
        exp_valid = 1'b0;
        exp_data  = 8'd0;
        exp_count = 4'd0;
        for (int i = 0; i < 9; i++) begin
            da = 8'hA0 + 8'(i);
            db = 8'hB0 + 8'(i);
            applyStimulus(1'b1, da, 1'b1, db, 1'b1);
`ifdef FIFO_ARB_RD_PRIO_EN
            case (i % 4)
                0:       exp_g = 3'b100;
                2:       exp_g = 3'b010;
                default: exp_g = 3'b001;
            endcase
`else
            case (i % 3)
                0:       exp_g = 3'b100;
                1:       exp_g = 3'b010;
                default: exp_g = 3'b001;
            endcase
`endif
            checkOutput("fair_rdvalid", 32'(rd_valid), 32'(exp_valid));
            if (exp_valid) checkOutput("fair_rddata", 32'(rd_data), 32'(exp_data));
            checkOutput("fair_gnt", 32'(gnt_vec), 32'(exp_g));
            checkOutput("fair_count", 32'(count), 32'(exp_count));
            exp_valid = 1'b0;
            if (exp_g == 3'b100) begin
                q.push_back(da);
                exp_count = exp_count + 4'd1;
            end else if (exp_g == 3'b010) begin
                q.push_back(db);
                exp_count = exp_count + 4'd1;
            end else begin
                exp_data  = q.pop_front();
                exp_valid = 1'b1;
                exp_count = exp_count - 4'd1;
            end
        end

        // Full contention: only the reader may go, then a writer follows.
        resetDut();
        fillWords(8, 8'h31);
        applyStimulus(1'b1, 8'h41, 1'b1, 8'h51, 1'b1);
        checkOutput("cont_count", 32'(count), 32'd8);
        checkOutput("cont_gnt", 32'(gnt_vec), 32'(3'b001));
        applyStimulus(1'b1, 8'h42, 1'b1, 8'h52, 1'b1);
        checkOutput("cont_count2", 32'(count), 32'd7);
        checkOutput("cont_rdvalid", 32'(rd_valid), 32'd1);
        checkOutput("cont_rddata", 32'(rd_data), 32'h31);
`ifdef FIFO_ARB_RD_PRIO_EN
        checkOutput("cont_gnt2", 32'(gnt_vec), 32'(3'b001));
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        checkOutput("cont_count3", 32'(count), 32'd6);
`else
        checkOutput("cont_gnt2", 32'(gnt_vec), 32'(3'b100));
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        checkOutput("cont_count3", 32'(count), 32'd8);
        checkOutput("cont_full", 32'(full), 32'd1);
`endif

        // Sticky error from a one-cycle FIFO error pulse.
        checkOutput("err_clean", 32'(err), 32'd0);
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        err_inject = 1'b1;
        #1;
        checkOutput("err_before", 32'(err), 32'd0);
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        err_inject = 1'b0;
        checkOutput("err_set", 32'(err), 32'd1);
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        checkOutput("err_hold", 32'(err), 32'd1);
        resetDut();
        #1;
        checkOutput("err_cleared", 32'(err), 32'd0);

        // Reset right after a read grant discards everything.
        fillWords(5, 8'h61);
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        checkOutput("midrst_count", 32'(count), 32'd5);
        checkOutput("midrst_gnt", 32'(rd_gnt), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_forced", 32'(gnt_vec), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        wr0_req = 1'b1;
        wr1_req = 1'b1;
        rd_req  = 1'b1;
        #1;
        checkOutput("midrst_count0", 32'(count), 32'd0);
        checkOutput("midrst_empty", 32'(empty), 32'd1);
        checkOutput("midrst_rdvalid", 32'(rd_valid), 32'd0);
        checkOutput("midrst_first", 32'(gnt_vec), 32'(3'b100));
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        checkOutput("midrst_after", 32'(count), 32'd1);
        checkOutput("final_err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_arbiter.md
# fifo_arbiter

Three-way arbiter that shares one 8-entry, 8-bit synchronous FIFO between two write requesters and one read requester. It sits directly in front of the FIFO, drives its wen/ren/din, and keeps a shadow occupancy count, so the FIFO is never given an illegal operation. That means no read when empty, no write when full, and never wen and ren together. It grants at most one operation per cycle and returns read data with a valid strobe aligned to the FIFO's registered output.

## Interface
- DW, 8: data width; must equal FIFO width.
- DEPTH, 8: FIFO depth; must equal FIFO depth.
- CW, 4: count width, log2(DEPTH)+1.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low; the same net also resets the FIFO.
- wr0_req  in  1  requester 0 wants to write wr0_data this cycle.
- wr0_data  in  DW  requester 0 write data.
- wr0_gnt  out  1  requester 0 write accepted this cycle (combinational).
- wr1_req  in  1  requester 1 wants to write.
- wr1_data  in  DW  requester 1 write data.
- wr1_gnt  out  1  requester 1 write accepted this cycle (combinational).
- rd_req  in  1  reader wants one word.
- rd_gnt  out  1  read issued this cycle (combinational).
- rd_valid  out  1  rd_data holds the word read in the previous cycle (registered).
- rd_data  out  DW  pass-through of fifo_dout.
- fifo_wen  out  1  to FIFO wen.
- fifo_ren  out  1  to FIFO ren.
- fifo_din  out  DW  to FIFO din; the granted writer's data, else 0.
- fifo_dout  in  DW  from FIFO dout.
- fifo_error  in  1  from FIFO error.
- count  out  CW  shadow occupancy, 0..DEPTH.
- full  out  1  count == DEPTH (registered-derived).
- empty  out  1  count == 0.
- err  out  1  sticky; set when fifo_error is sampled high.

## Operation
- Eligibility:
  - Writer k is eligible when wrk_req=1 and count<DEPTH.
  - Reader is eligible when rd_req=1 and count>0.
- Round-robin pointer ptr is in {0=wr0, 1=wr1, 2=rd}. The search order is ptr, ptr+1, ptr+2 (mod 3). The first eligible requester gets the grant.
- After a grant to slot k: ptr <= (k+1) mod 3. With no grant, ptr holds.
- Exactly zero or one of wr0_gnt/wr1_gnt/rd_gnt is high.
- fifo_wen = wr0_gnt|wr1_gnt. fifo_ren = rd_gnt. fifo_wen and fifo_ren are never both 1.
- Count update: count +1 on a write grant, −1 on a read grant, otherwise hold. Arithmetic never wraps, because eligibility guarantees this.
- rd_valid <= rd_gnt. rd_data = fifo_dout always; it is meaningful only when rd_valid=1.
- err <= err | fifo_error. It clears only on reset. In correct operation it never sets.
- Requests not granted are not queued. The requester holds req until it sees gnt.

## Timing
- Reset (rst_n=0 at an edge):
  - count=0, ptr=0, rd_valid=0, err=0.
  - All grants, fifo_wen and fifo_ren are forced 0 while rst_n=0.
  - empty=1, full=0.
- Grant latency: 0 cycles. gnt is asserted in the same cycle as req when eligible. Data is written at that edge.
- Read latency: 1 cycle. rd_valid and the data appear the cycle after rd_gnt.
- Full: write requests see gnt=0. A read may still be granted; count DEPTH→DEPTH−1 at the edge, and writers become eligible the next cycle.
- Empty: rd_req sees rd_gnt=0. A write in the same cycle does not enable a read until the following cycle, because eligibility uses registered count.
- Reset mid-operation: contents are discarded.
  - FIFO and shadow count both return to 0 at the same edge.
  - A read granted in the cycle before reset still produces rd_valid=0 after the reset edge.

## Configuration
- FIFO_ARB_RD_PRIO_EN defined:
  - The reader has strict priority whenever it is eligible.
  - The writers round-robin only between themselves (ptr toggles 0/1). A read grant does not move ptr.
- Not defined: the 3-way round-robin above.

## Test plan
- Fill: after reset, wr0_req=1 with data 0x11..0x18 over 8 cycles. Expect:
  - wr0_gnt=1 each cycle; count 1..8; full=1 after 8th edge.
  - 9th request gives wr0_gnt=0 and fifo_wen=0.
- Drain: from the fill state, hold rd_req=1 for 9 cycles. Expect:
  - rd_gnt=1 for 8 cycles; rd_valid a cycle later with rd_data 0x11..0x18 in order.
  - Then empty=1, and the 9th cycle gives rd_gnt=0 and fifo_ren=0.
- Fairness: from empty, all three requests held high. Expect:
  - Grant sequence wr0, wr1, rd, wr0, wr1, rd…; count +1 every 3 cycles.
  - With FIFO_ARB_RD_PRIO_EN the sequence is wr0, rd, wr1, rd… and count stays ≤1.
- Full contention: at count=8, all three requests high. Expect only rd_gnt=1; count 7; next cycle a writer is granted per ptr.
- Error: the bench forces fifo_error=1 for one cycle. Expect err=1 from the next edge, held until rst_n=0.
- Mid-op reset: at count=5 with rd_gnt=1, assert rst_n=0 for one edge. Expect count=0, empty=1, rd_valid=0, and first post-reset grant to wr0.
